data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder_pkg.sv | 6 +
 rtl/data_mem_wbuf.sv | 55 +++++
 rtl/data_mem_responder.sv | 92 +++++++++
 tb/tb_data_mem_responder.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// data_mem_responder_pkg: shared defaults and FSM encoding for the data memory responder
package data_mem_responder_pkg;
  localparam int DEF_AW = 10;
  localparam int DEF_WB_DEPTH = 4;
  typedef enum logic [1:0] {IDLE, WR_BUSY, RD_BUSY, RD_DONE} state_t;
endpackage

// File: rtl/data_mem_wbuf.sv
// data_mem_wbuf: store FIFO with associative youngest-match load lookup
module data_mem_wbuf
  import data_mem_responder_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DEPTH = DEF_WB_DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_addr,
  input  logic [31:0]   push_data,
  input  logic [AW-1:0] look_addr,
  output logic          full,
  output logic          empty,
  output logic [AW-1:0] head_addr,
  output logic [31:0]   head_data,
  output logic          hit,
  output logic [31:0]   hit_data
);
  localparam int PW = $clog2(DEPTH);
  logic [AW-1:0] addr_q [DEPTH];
  logic [31:0] data_q [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] count;
  assign full = count == (PW+1)'(DEPTH);
  assign empty = count == '0;
  assign head_addr = addr_q[rd_ptr];
  assign head_data = data_q[rd_ptr];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push) begin
      addr_q[wr_ptr] <= push_addr;
      data_q[wr_ptr] <= push_data;
    end
  always_comb begin
    hit = 1'b0;
    hit_data = '0;
    for (int i = 0; i < DEPTH; i++)
      if ((PW+1)'(i) < count && addr_q[rd_ptr + PW'(i)] == look_addr) begin
        hit = 1'b1;
        hit_data = data_q[rd_ptr + PW'(i)];
      end
  end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: CPU data port with write buffer, load bypass and single-port SRAM sequencer
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int WB_DEPTH = DEF_WB_DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          memen,
  input  logic          memwrite,
  input  logic [31:0]   aluout,
  input  logic [31:0]   writedata,
  output logic [31:0]   readdata,
  output logic          stall,
  output logic          sram_req,
  output logic          sram_we,
  output logic [AW-1:0] sram_addr,
  output logic [31:0]   sram_wdata,
  input  logic          sram_ack,
  input  logic [31:0]   sram_rdata
);
  state_t state, state_d;
  logic hit, full, empty, push, pop, issue_rd, issue_wr, load, load_miss, unused_bits;
  logic [AW-1:0] word_addr, head_addr;
  logic [31:0] head_data, hit_data, rdata_q;
  assign word_addr = aluout[AW+1:2];
  assign unused_bits = ^{aluout[31:AW+2], aluout[1:0]};
  assign load = memen & ~memwrite;
  assign load_miss = load & ~hit;
  assign push = memen & memwrite & ~full;
  assign stall = ~reset & memen & (memwrite ? full : ~(hit | state == RD_DONE));
  assign readdata = (reset | ~load) ? '0 : hit ? hit_data : state == RD_DONE ? rdata_q : '0;
  data_mem_wbuf #(.AW(AW), .DEPTH(WB_DEPTH)) u_wbuf (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .push_addr(word_addr),
    .push_data(writedata),
    .look_addr(word_addr),
    .full(full),
    .empty(empty),
    .head_addr(head_addr),
    .head_data(head_data),
    .hit(hit),
    .hit_data(hit_data)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_d;
  always_comb begin
    state_d = state;
    issue_rd = 1'b0;
    issue_wr = 1'b0;
    pop = 1'b0;
    case (state)
      IDLE:
        if (load_miss) begin
          state_d = RD_BUSY;
          issue_rd = 1'b1;
        end else if (!empty) begin
          state_d = WR_BUSY;
          issue_wr = 1'b1;
        end
      WR_BUSY:
        if (sram_ack) begin
          state_d = IDLE;
          pop = 1'b1;
        end
      RD_BUSY: state_d = sram_ack ? RD_DONE : RD_BUSY;
      RD_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sram_req <= 1'b0;
      sram_we <= 1'b0;
      sram_addr <= '0;
      sram_wdata <= '0;
      rdata_q <= '0;
    end else begin
      if (issue_rd | issue_wr) begin
        sram_req <= 1'b1;
        sram_we <= issue_wr;
        sram_addr <= issue_wr ? head_addr : word_addr;
        sram_wdata <= issue_wr ? head_data : '0;
      end else if (sram_ack) sram_req <= 1'b0;
      if (state == RD_BUSY && sram_ack) rdata_q <= sram_rdata;
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: scoreboard bench with SRAM model for data_mem_responder
module tb_data_mem_responder;
  import data_mem_responder_pkg::*;
  localparam int AW = 10;
  logic clk = 1'b0, reset = 1'b1, memen = 1'b0, memwrite = 1'b0;
  logic [31:0] aluout = '0, writedata = '0, readdata, sram_wdata, sram_rdata = '0;
  logic stall, sram_req, sram_we, sram_ack = 1'b0;
  logic [AW-1:0] sram_addr;
  int n_checks = 0, n_pass = 0, ack_delay = 1, rd_count = 0, cnt = 0;
  logic [31:0] smem [1024];
  logic [31:0] rmem [1024];
  logic [AW+31:0] exp_wr [$];
  logic [31:0] rd_q [$];
  bit ops_log [$];
  bit held = 1'b0;
  logic [AW-1:0] h_addr;
  logic h_we;
  logic [31:0] h_wdata;
  logic [AW+31:0] e_wr;

  always #5 clk = ~clk;

  data_mem_responder #(.AW(AW), .WB_DEPTH(4)) dut (
    .clk(clk),
    .reset(reset),
    .memen(memen),
    .memwrite(memwrite),
    .aluout(aluout),
    .writedata(writedata),
    .readdata(readdata),
    .stall(stall),
    .sram_req(sram_req),
    .sram_we(sram_we),
    .sram_addr(sram_addr),
    .sram_wdata(sram_wdata),
    .sram_ack(sram_ack),
    .sram_rdata(sram_rdata)
  );

  always @(negedge clk) begin
    if (reset) begin
      sram_ack = 1'b0;
      cnt = 0;
      held = 1'b0;
    end else if (sram_ack) begin
      sram_ack = 1'b0;
      cnt = 0;
      held = 1'b0;
    end else if (sram_req) begin
      if (held) begin
        n_checks++;
        if ({sram_addr, sram_we, sram_wdata} !== {h_addr, h_we, h_wdata})
          $display("FAIL sram_stable: got addr=%h we=%b wdata=%h want addr=%h we=%b wdata=%h",
                   sram_addr, sram_we, sram_wdata, h_addr, h_we, h_wdata);
        else n_pass++;
      end
      held = 1'b1;
      h_addr = sram_addr;
      h_we = sram_we;
      h_wdata = sram_wdata;
      cnt++;
      if (cnt >= ack_delay) begin
        sram_ack = 1'b1;
        if (sram_we) begin
          ops_log.push_back(1'b1);
          smem[sram_addr] = sram_wdata;
          n_checks++;
          if (exp_wr.size() == 0)
            $display("FAIL sram_write_order: got addr=%h data=%h want no write", sram_addr, sram_wdata);
          else begin
            e_wr = exp_wr.pop_front();
            if ({sram_addr, sram_wdata} !== e_wr)
              $display("FAIL sram_write_order: got addr=%h data=%h want addr=%h data=%h",
                       sram_addr, sram_wdata, e_wr[AW+31:32], e_wr[31:0]);
            else n_pass++;
          end
        end else begin
          ops_log.push_back(1'b0);
          rd_count++;
          sram_rdata = smem[sram_addr];
        end
      end
    end
  end

  task automatic idle();
    memen = 1'b0;
    memwrite = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, output int stalls);
    memen = 1'b1;
    memwrite = 1'b1;
    aluout = a;
    writedata = d;
    stalls = 0;
    @(negedge clk);
    while (stall && stalls < 100) begin
      stalls++;
      @(negedge clk);
    end
    n_checks++;
    if (stall) $display("FAIL store_accept: addr=%h got stall=%b want 0 within 100 cycles", a, stall);
    else begin
      n_pass++;
      exp_wr.push_back({a[AW+1:2], d});
      rmem[a[AW+1:2]] = d;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [31:0] a, output int stalls);
    logic [31:0] e;
    memen = 1'b1;
    memwrite = 1'b0;
    aluout = a;
    rd_q.push_back(rmem[a[AW+1:2]]);
    stalls = 0;
    @(negedge clk);
    while (stall && stalls < 100) begin
      stalls++;
      @(negedge clk);
    end
    e = rd_q.pop_front();
    n_checks++;
    if (stall || readdata !== e)
      $display("FAIL load_data: addr=%h got readdata=%h stall=%b want readdata=%h stall=0", a, readdata, stall, e);
    else n_pass++;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int k = 0;
    memen = 1'b0;
    memwrite = 1'b0;
    while ((exp_wr.size() != 0 || sram_req) && k < 300) begin
      @(posedge clk);
      #1;
      k++;
    end
    n_checks++;
    if (exp_wr.size() != 0 || sram_req)
      $display("FAIL drain: got pending=%0d sram_req=%b want 0 and 0", exp_wr.size(), sram_req);
    else n_pass++;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    memen = 1'b1;
    memwrite = 1'b0;
    aluout = 32'h44;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({sram_req, sram_we, sram_addr, sram_wdata} !== '0)
      $display("FAIL reset_sram: got req=%b we=%b addr=%h wdata=%h want all 0", sram_req, sram_we, sram_addr, sram_wdata);
    else n_pass++;
    n_checks++;
    if (stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall);
    else n_pass++;
    n_checks++;
    if (readdata !== 32'h0) $display("FAIL reset_readdata: got %h want 0", readdata);
    else n_pass++;
    n_checks++;
    if (dut.state !== IDLE) $display("FAIL reset_state: got %0d want IDLE", dut.state);
    else n_pass++;
    memen = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (readdata !== 32'h0 || stall !== 1'b0) $display("FAIL idle_outputs: got readdata=%h stall=%b want 0 0", readdata, stall);
    else n_pass++;
  endtask

  task automatic test_store_load_hit();
    int s, r0;
    ack_delay = 1;
    do_store(32'h10, 32'hAAAA5555, s);
    r0 = rd_count;
    do_load(32'h10, s);
    n_checks++;
    if (s != 0 || rd_count != r0) $display("FAIL hit_no_stall: got stalls=%0d reads=%0d want 0 stalls %0d reads", s, rd_count, r0);
    else n_pass++;
    wait_drain();
  endtask

  task automatic test_dup_store();
    int s;
    do_store(32'h20, 32'h1, s);
    do_store(32'h20, 32'h2, s);
    do_load(32'h21, s);
    n_checks++;
    if (s != 0) $display("FAIL dup_hit_stall: got stalls=%0d want 0", s);
    else n_pass++;
    wait_drain();
    n_checks++;
    if (smem[8] !== 32'h2) $display("FAIL dup_final: got %h want 00000002", smem[8]);
    else n_pass++;
  endtask

  task automatic test_full_stall();
    int s [5];
    ack_delay = 3;
    for (int i = 0; i < 5; i++) do_store(32'h80 + 32'(4 * i), 32'h1000 + 32'(i), s[i]);
    idle();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (s[i] != 0) $display("FAIL fill_no_stall: store %0d got stalls=%0d want 0", i, s[i]);
      else n_pass++;
    end
    n_checks++;
    if (s[4] < 1) $display("FAIL full_stall: got stalls=%0d want >=1", s[4]);
    else n_pass++;
    wait_drain();
  endtask

  task automatic test_load_miss();
    int s, r0;
    ack_delay = 2;
    smem[16] = 32'hDEADBEEF;
    rmem[16] = 32'hDEADBEEF;
    r0 = rd_count;
    do_load(32'h40, s);
    idle();
    n_checks++;
    if (s < 2 || rd_count != r0 + 1) $display("FAIL miss_stall: got stalls=%0d reads=%0d want >=2 stalls %0d reads", s, rd_count, r0 + 1);
    else n_pass++;
    n_checks++;
    if (readdata !== 32'h0) $display("FAIL post_load_readdata: got %h want 0", readdata);
    else n_pass++;
  endtask

  task automatic test_miss_during_write();
    int s;
    ack_delay = 3;
    ops_log.delete();
    do_store(32'h100, 32'h55, s);
    idle();
    n_checks++;
    if (sram_req !== 1'b1 || sram_we !== 1'b1) $display("FAIL wr_busy: got req=%b we=%b want 1 1", sram_req, sram_we);
    else n_pass++;
    do_load(32'h200, s);
    wait_drain();
    n_checks++;
    if (ops_log.size() != 2 || ops_log[0] != 1'b1 || ops_log[1] != 1'b0)
      $display("FAIL write_then_read: got %0d ops first_we=%b want 2 ops write then read",
               ops_log.size(), ops_log.size() > 0 ? ops_log[0] : 1'b0);
    else n_pass++;
  endtask

  task automatic test_reset_rd_busy();
    int s, k;
    ack_delay = 20;
    do_store(32'h300, 32'h12345678, s);
    memen = 1'b1;
    memwrite = 1'b0;
    aluout = 32'h304;
    k = 0;
    while (!sram_req && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    n_checks++;
    if (sram_req !== 1'b1 || sram_we !== 1'b0) $display("FAIL rd_busy: got req=%b we=%b want 1 0", sram_req, sram_we);
    else n_pass++;
    reset = 1'b1;
    #1;
    n_checks++;
    if (sram_req !== 1'b0 || stall !== 1'b0) $display("FAIL async_reset: got req=%b stall=%b want 0 0", sram_req, stall);
    else n_pass++;
    memen = 1'b0;
    exp_wr.delete();
    rd_q.delete();
    for (int i = 0; i < 1024; i++) rmem[i] = smem[i];
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    n_checks++;
    if (dut.state !== IDLE || sram_req !== 1'b0) $display("FAIL post_reset: got state=%0d req=%b want IDLE 0", dut.state, sram_req);
    else n_pass++;
    ack_delay = 1;
    do_load(32'h300, s);
    n_checks++;
    if (s == 0) $display("FAIL discarded_store: got stalls=0 want miss after reset");
    else n_pass++;
    wait_drain();
  endtask

  task automatic test_mixed();
    int s;
    logic [31:0] a;
    for (int i = 0; i < 40; i++) begin
      ack_delay = $urandom_range(1, 3);
      a = 32'h400 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) do_load(a, s);
      else do_store(a, $urandom, s);
    end
    wait_drain();
    for (int i = 0; i < 8; i++) do_load(32'h400 + 32'(4 * i), s);
    idle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      smem[i] = 32'(i) * 32'h9E3779B1;
      rmem[i] = smem[i];
    end
    test_reset();
    test_store_load_hit();
    test_dup_store();
    test_full_stall();
    test_load_miss();
    test_miss_during_write();
    test_reset_rd_busy();
    test_mixed();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
